// File: rtl/tetris_game_engine.sv
// Playfield engine: fixed board plus one active piece, spawn/fall/lock/clear/over FSM with line counter.
// Define TETRIS_HARD_DROP_EN for a multi-cycle hard drop (one row per cycle); otherwise HARD_DROP is a NOP.
module tetris_game_engine #(
   parameter int BOARD_W = 10,
   parameter int BOARD_H = 20,
   parameter int LINES_W = 16,
   parameter int SPAWN_X = 3
) (
   input  logic                       i_clk,
   input  logic                       i_reset,
   input  logic                       i_gravity_tick,
   input  logic                       i_move_valid,
   output logic                       o_move_ready,
   input  logic [2:0]                 i_move,
   input  logic                       i_piece_valid,
   output logic                       o_piece_ready,
   input  logic [2:0]                 i_piece_type,
   output logic [BOARD_W*BOARD_H-1:0] o_board,
   output logic [LINES_W-1:0]         o_lines_cleared,
   output logic                       o_game_over,
   output logic [2:0]                 o_fsm_state
);
   localparam int CELLS = BOARD_W * BOARD_H;
   localparam int XW    = $clog2(BOARD_W) + 2;
   localparam int YW    = $clog2(BOARD_H) + 1;
   localparam int RW    = $clog2(BOARD_H);

   localparam logic [2:0] MV_LEFT  = 3'd1;
   localparam logic [2:0] MV_RIGHT = 3'd2;
   localparam logic [2:0] MV_ROT   = 3'd3;
   localparam logic [2:0] MV_SOFT  = 3'd4;
   localparam logic [2:0] MV_HARD  = 3'd5;

   typedef enum logic [2:0] {
      S_SPAWN = 3'd0,
      S_FALL  = 3'd1,
      S_LOCK  = 3'd2,
      S_CLEAR = 3'd3,
      S_OVER  = 3'd4
   } state_t;

   // 4x4 masks, bit r*4+c; type 0 (and 7) is I.
   function automatic logic [15:0] shape(input logic [2:0] t, input logic [1:0] rot);
      logic [15:0] m;
      m = 16'h0000;
      case (t)
         3'd1: m = 16'h0066;
         3'd2: case (rot) 2'd0: m = 16'h0072; 2'd1: m = 16'h0262; 2'd2: m = 16'h0270; default: m = 16'h0232; endcase
         3'd3: case (rot) 2'd0: m = 16'h0036; 2'd1: m = 16'h0462; 2'd2: m = 16'h0360; default: m = 16'h0231; endcase
         3'd4: case (rot) 2'd0: m = 16'h0063; 2'd1: m = 16'h0264; 2'd2: m = 16'h0630; default: m = 16'h0132; endcase
         3'd5: case (rot) 2'd0: m = 16'h0071; 2'd1: m = 16'h0226; 2'd2: m = 16'h0470; default: m = 16'h0322; endcase
         3'd6: case (rot) 2'd0: m = 16'h0074; 2'd1: m = 16'h0622; 2'd2: m = 16'h0170; default: m = 16'h0223; endcase
         default: case (rot) 2'd0: m = 16'h00F0; 2'd1: m = 16'h4444; 2'd2: m = 16'h0F00; default: m = 16'h2222; endcase
      endcase
      return m;
   endfunction

   function automatic logic collides(input logic [CELLS-1:0] fixed, input logic [15:0] m,
                                     input int x, input int y);
      logic hit;
      int   col;
      int   row;
      hit = 1'b0;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            col = x + c;
            row = y + r;
            if (m[r*4+c]) begin
               if (col < 0 || col >= BOARD_W || row < 0 || row >= BOARD_H) hit = 1'b1;
               else if (fixed[row*BOARD_W+col]) hit = 1'b1;
            end
         end
      end
      return hit;
   endfunction

   function automatic logic [CELLS-1:0] paint(input logic [15:0] m, input int x, input int y);
      logic [CELLS-1:0] v;
      int               col;
      int               row;
      v = '0;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            col = x + c;
            row = y + r;
            if (m[r*4+c] && col >= 0 && col < BOARD_W && row >= 0 && row < BOARD_H)
               v[row*BOARD_W+col] = 1'b1;
         end
      end
      return v;
   endfunction

   state_t                  r_state, w_state_nxt;
   logic [CELLS-1:0]        r_fixed, w_fixed_nxt;
   logic [2:0]              r_type, w_type_nxt;
   logic [1:0]              r_rot, w_rot_nxt;
   logic signed [XW-1:0]    r_x, w_x_nxt;
   logic [YW-1:0]           r_y, w_y_nxt;
   logic                    r_active, w_active_nxt;
   logic [RW-1:0]           r_row, w_row_nxt;
   logic [LINES_W-1:0]      r_lines, w_lines_nxt;
   logic                    r_over, w_over_nxt;
   logic                    r_live;
`ifdef TETRIS_HARD_DROP_EN
   logic                    r_hd, w_hd_nxt;
`endif

   logic [15:0]      w_mask;
   logic [2:0]       w_spawn_type;
   logic             w_hit_down, w_hit_left, w_hit_right, w_hit_rot, w_hit_spawn;
   logic             w_row_full;
   logic [CELLS-1:0] w_piece_cells;

   assign w_mask        = shape(r_type, r_rot);
   assign w_spawn_type  = (i_piece_type == 3'd7) ? 3'd0 : i_piece_type;
   assign w_hit_down    = collides(r_fixed, w_mask, int'(r_x), int'(r_y) + 1);
   assign w_hit_left    = collides(r_fixed, w_mask, int'(r_x) - 1, int'(r_y));
   assign w_hit_right   = collides(r_fixed, w_mask, int'(r_x) + 1, int'(r_y));
   assign w_hit_rot     = collides(r_fixed, shape(r_type, r_rot + 2'd1), int'(r_x), int'(r_y));
   assign w_hit_spawn   = collides(r_fixed, shape(w_spawn_type, 2'd0), SPAWN_X, 0);
   assign w_row_full    = &r_fixed[int'(r_row)*BOARD_W +: BOARD_W];
   assign w_piece_cells = paint(w_mask, int'(r_x), int'(r_y));

   assign o_board         = r_fixed | (r_active ? w_piece_cells : '0);
   assign o_lines_cleared = r_lines;
   assign o_game_over     = r_over;
   assign o_fsm_state     = r_state;

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) r_state <= S_SPAWN;
      else         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_fixed_nxt   = r_fixed;
      w_type_nxt    = r_type;
      w_rot_nxt     = r_rot;
      w_x_nxt       = r_x;
      w_y_nxt       = r_y;
      w_active_nxt  = r_active;
      w_row_nxt     = r_row;
      w_lines_nxt   = r_lines;
      w_over_nxt    = r_over;
`ifdef TETRIS_HARD_DROP_EN
      w_hd_nxt      = r_hd;
`endif
      o_move_ready  = 1'b0;
      o_piece_ready = 1'b0;
      case (r_state)
         S_SPAWN: begin
            o_piece_ready = r_live;
            if (r_live && i_piece_valid) begin
               w_type_nxt = w_spawn_type;
               w_rot_nxt  = 2'd0;
               w_x_nxt    = XW'(SPAWN_X);
               w_y_nxt    = '0;
               if (w_hit_spawn) begin
                  w_state_nxt = S_OVER;
                  w_over_nxt  = 1'b1;
               end else begin
                  w_state_nxt  = S_FALL;
                  w_active_nxt = 1'b1;
               end
            end
         end
         S_FALL: begin
`ifdef TETRIS_HARD_DROP_EN
            if (r_hd) begin
               if (w_hit_down) begin
                  w_state_nxt = S_LOCK;
                  w_hd_nxt    = 1'b0;
               end else begin
                  w_y_nxt = r_y + YW'(1);
               end
            end else
`endif
            if (i_gravity_tick) begin
               if (w_hit_down) w_state_nxt = S_LOCK;
               else            w_y_nxt     = r_y + YW'(1);
            end else begin
               // Moves are rejected outright on collision; there is no wall kick.
               o_move_ready = 1'b1;
               if (i_move_valid) begin
                  case (i_move)
                     MV_LEFT:  if (!w_hit_left)  w_x_nxt   = r_x - XW'(1);
                     MV_RIGHT: if (!w_hit_right) w_x_nxt   = r_x + XW'(1);
                     MV_ROT:   if (!w_hit_rot)   w_rot_nxt = r_rot + 2'd1;
                     MV_SOFT:  if (!w_hit_down)  w_y_nxt   = r_y + YW'(1);
`ifdef TETRIS_HARD_DROP_EN
                     MV_HARD: begin
                        if (w_hit_down) begin
                           w_state_nxt = S_LOCK;
                        end else begin
                           w_y_nxt  = r_y + YW'(1);
                           w_hd_nxt = 1'b1;
                        end
                     end
`endif
                     default: ;
                  endcase
               end
            end
         end
         S_LOCK: begin
            w_fixed_nxt  = r_fixed | w_piece_cells;
            w_active_nxt = 1'b0;
            w_row_nxt    = RW'(BOARD_H - 1);
            w_state_nxt  = S_CLEAR;
         end
         S_CLEAR: begin
            if (w_row_full) begin
               // Rows above the full one drop by one; the same row is rescanned next cycle.
               for (int rr = 1; rr < BOARD_H; rr++) begin
                  if (rr <= int'(r_row))
                     w_fixed_nxt[rr*BOARD_W +: BOARD_W] = r_fixed[(rr-1)*BOARD_W +: BOARD_W];
               end
               w_fixed_nxt[0 +: BOARD_W] = '0;
               if (r_lines != {LINES_W{1'b1}}) w_lines_nxt = r_lines + LINES_W'(1);
            end else if (r_row == '0) begin
               w_state_nxt = S_SPAWN;
            end else begin
               w_row_nxt = r_row - RW'(1);
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_fixed  <= '0;
         r_type   <= '0;
         r_rot    <= '0;
         r_x      <= '0;
         r_y      <= '0;
         r_active <= 1'b0;
         r_row    <= '0;
         r_lines  <= '0;
         r_over   <= 1'b0;
         r_live   <= 1'b0;
`ifdef TETRIS_HARD_DROP_EN
         r_hd     <= 1'b0;
`endif
      end else begin
         r_fixed  <= w_fixed_nxt;
         r_type   <= w_type_nxt;
         r_rot    <= w_rot_nxt;
         r_x      <= w_x_nxt;
         r_y      <= w_y_nxt;
         r_active <= w_active_nxt;
         r_row    <= w_row_nxt;
         r_lines  <= w_lines_nxt;
         r_over   <= w_over_nxt;
         r_live   <= 1'b1;
`ifdef TETRIS_HARD_DROP_EN
         r_hd     <= w_hd_nxt;
`endif
      end
   end
endmodule
